// File: rtl/vga_sincronismo_if.sv
// Raster bus shared by the VGA timing generator and the drawing modules
// (ship, grid and shot renderers) of the Batalha Naval display.
interface vga_sincronismo_if;
    logic       hsync;
    logic       vsync;
    logic       areaAtiva;
    logic [9:0] coluna;
    logic [9:0] linha;
    logic       frameInicio;

    // Timing generator side: owns every raster signal.
    modport master (
        output hsync,
        output vsync,
        output areaAtiva,
        output coluna,
        output linha,
        output frameInicio
    );

    // Renderer / monitor side: reads the raster position and sync pins.
    modport slave (
        input hsync,
        input vsync,
        input areaAtiva,
        input coluna,
        input linha,
        input frameInicio
    );
endinterface

// File: rtl/vga_sincronismo.sv
// 640x480 @ 60 Hz VGA raster timing generator for the Batalha Naval display.
// A clock divider produces a pixel tick. On every tick the raster position
// advances. The sync and active-area flags are decoded from the *next*
// position, so every registered output describes the position currently
// shown on coluna/linha.
module vga_sincronismo #(
    parameter int DIV_CLK  = 2,
    parameter int H_ATIVO  = 640,
    parameter int H_FRENTE = 16,
    parameter int H_SINC   = 96,
    parameter int H_TRAS   = 48,
    parameter int V_ATIVO  = 480,
    parameter int V_FRENTE = 10,
    parameter int V_SINC   = 2,
    parameter int V_TRAS   = 33
) (
    input  logic             clk,
    input  logic             reset,
    vga_sincronismo_if.master vga
);

    localparam int H_TOTAL = H_ATIVO + H_FRENTE + H_SINC + H_TRAS;
    localparam int V_TOTAL = V_ATIVO + V_FRENTE + V_SINC + V_TRAS;

    // Sync pulse windows, as 10-bit bounds: [inicio, fim).
    localparam logic [9:0] H_ULTIMA     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ULTIMA     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ATIVO_W    = 10'(H_ATIVO);
    localparam logic [9:0] V_ATIVO_W    = 10'(V_ATIVO);
    localparam logic [9:0] HS_INICIO    = 10'(H_ATIVO + H_FRENTE);
    localparam logic [9:0] HS_FIM       = 10'(H_ATIVO + H_FRENTE + H_SINC);
    localparam logic [9:0] VS_INICIO    = 10'(V_ATIVO + V_FRENTE);
    localparam logic [9:0] VS_FIM       = 10'(V_ATIVO + V_FRENTE + V_SINC);

    // DIV_CLK goes up to 16, so the divider counts 0..15.
    localparam logic [3:0] DIV_ULTIMO   = 4'(DIV_CLK - 1);

    logic [3:0] div;
    logic       tick;

    logic [9:0] coluna_prox;
    logic [9:0] linha_prox;
    logic       area_prox;
    logic       hsync_prox;
    logic       vsync_prox;
    logic       frame_prox;

    assign tick = (div == DIV_ULTIMO);

    // Next raster position and the flags that will describe it.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        coluna_prox = vga.coluna + 10'd1;
        linha_prox  = vga.linha;
        if (vga.coluna >= H_ULTIMA) begin
            coluna_prox = '0;
            linha_prox  = (vga.linha >= V_ULTIMA) ? 10'd0 : vga.linha + 10'd1;
        end

        area_prox  = (coluna_prox < H_ATIVO_W) && (linha_prox < V_ATIVO_W);
        hsync_prox = !((coluna_prox >= HS_INICIO) && (coluna_prox < HS_FIM));
        vsync_prox = !((linha_prox  >= VS_INICIO) && (linha_prox  < VS_FIM));
        frame_prox = (coluna_prox == 10'd0) && (linha_prox == 10'd0);
    end

    // Divider, position and flag registers; reset parks at the last pixel.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            div             <= '0;
            vga.coluna      <= H_ULTIMA;
            vga.linha       <= V_ULTIMA;
            vga.areaAtiva   <= 1'b0;
            vga.hsync       <= 1'b1;
            vga.vsync       <= 1'b1;
            vga.frameInicio <= 1'b0;
        end else begin
            // Single-clock pulse: cleared on every edge unless re-armed below.
            vga.frameInicio <= 1'b0;
            if (tick) begin
                div             <= '0;
                vga.coluna      <= coluna_prox;
                vga.linha       <= linha_prox;
                vga.areaAtiva   <= area_prox;
                vga.hsync       <= hsync_prox;
                vga.vsync       <= vsync_prox;
                vga.frameInicio <= frame_prox;
            end else begin
                div <= div + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sincronismo.sv
// Self-checking bench for vga_sincronismo.
// Instance a: default 640x480 timing, DIV_CLK=2, checked with a vector table
// plus an asynchronous mid-line reset.
// Instance b: tiny 15x13 raster with DIV_CLK=1, checked every clock against a
// position model over two frames, plus an asynchronous mid-frame reset.
module tb_vga_sincronismo;

    typedef struct packed {
        logic [9:0] coluna;
        logic [9:0] linha;
        logic       area;
        logic       hs;
        logic       vs;
        logic       fi;
    } out_t;

    typedef struct {
        logic  rst;
        int    n;
        out_t  exp;
        string name;
    } vec_t;

    // Tiny raster for instance b.
    localparam int B_HA = 8, B_HF = 2, B_HS = 3, B_HB = 2;
    localparam int B_VA = 6, B_VF = 2, B_VS = 2, B_VB = 3;
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;   // 15
    localparam int B_VT = B_VA + B_VF + B_VS + B_VB;   // 13
    localparam int B_FRAME = B_HT * B_VT;               // 195

    logic clk;
    logic rst_a;
    logic rst_b;

    vga_sincronismo_if bus_a ();
    vga_sincronismo_if bus_b ();

    vga_sincronismo u_a (
        .clk   (clk),
        .reset (rst_a),
        .vga   (bus_a)
    );

    vga_sincronismo #(
        .DIV_CLK  (1),
        .H_ATIVO  (B_HA), .H_FRENTE (B_HF), .H_SINC (B_HS), .H_TRAS (B_HB),
        .V_ATIVO  (B_VA), .V_FRENTE (B_VF), .V_SINC (B_VS), .V_TRAS (B_VB)
    ) u_b (
        .clk   (clk),
        .reset (rst_b),
        .vga   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t exp_q[$];

    function automatic out_t mk(int col, int lin, bit area, bit hs, bit vs, bit fi);
        out_t o;
        o.coluna = 10'(col);
        o.linha  = 10'(lin);
        o.area   = area;
        o.hs     = hs;
        o.vs     = vs;
        o.fi     = fi;
        return o;
    endfunction

    function automatic out_t sample_a();
        return mk(int'(bus_a.coluna), int'(bus_a.linha), bus_a.areaAtiva,
                  bus_a.hsync, bus_a.vsync, bus_a.frameInicio);
    endfunction

    function automatic out_t sample_b();
        return mk(int'(bus_b.coluna), int'(bus_b.linha), bus_b.areaAtiva,
                  bus_b.hsync, bus_b.vsync, bus_b.frameInicio);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input out_t e);
        exp_q.push_back(e);
    endtask

    task automatic check_pop(input string name, input out_t act);
        out_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        e = exp_q.pop_front();
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got col=%0d lin=%0d area=%0b hs=%0b vs=%0b fi=%0b, expected col=%0d lin=%0d area=%0b hs=%0b vs=%0b fi=%0b",
                     name, act.coluna, act.linha, act.area, act.hs, act.vs, act.fi,
                     e.coluna, e.linha, e.area, e.hs, e.vs, e.fi);
        end
    endtask

    // Independent model of instance b: position index p counts ticks since
    // release, outputs are decoded straight from (col, lin).
    function automatic out_t model_b(int p, bit fi);
        int col = p % B_HT;
        int lin = p / B_HT;
        return mk(col, lin,
                  (col < B_HA) && (lin < B_VA),
                  !((col >= B_HA + B_HF) && (col < B_HA + B_HF + B_HS)),
                  !((lin >= B_VA + B_VF) && (lin < B_VA + B_VF + B_VS)),
                  fi);
    endfunction

    // Watchdog: the whole run is well under this bound.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[17];
        int   fi_count;
        int   vs_low;

        rst_a = 1'b1;
        rst_b = 1'b1;

        // Default raster: each position held 2 clocks; counts are clocks to
        // the sample point from the previous row's sample point.
        tbl[0]  = '{1'b1, 5,     mk(799, 524, 0, 1, 1, 0), "a_reset_hold"};
        tbl[1]  = '{1'b0, 1,     mk(799, 524, 0, 1, 1, 0), "a_release_edge1"};
        tbl[2]  = '{1'b0, 1,     mk(0,   0,   1, 1, 1, 1), "a_first_tick"};
        tbl[3]  = '{1'b0, 1,     mk(0,   0,   1, 1, 1, 0), "a_frame_pulse_clear"};
        tbl[4]  = '{1'b0, 1,     mk(1,   0,   1, 1, 1, 0), "a_col1"};
        tbl[5]  = '{1'b0, 1,     mk(1,   0,   1, 1, 1, 0), "a_col1_hold"};
        tbl[6]  = '{1'b0, 1275,  mk(639, 0,   1, 1, 1, 0), "a_col639"};
        tbl[7]  = '{1'b0, 2,     mk(640, 0,   0, 1, 1, 0), "a_col640_inactive"};
        tbl[8]  = '{1'b0, 30,    mk(655, 0,   0, 1, 1, 0), "a_col655"};
        tbl[9]  = '{1'b0, 2,     mk(656, 0,   0, 0, 1, 0), "a_hsync_fall"};
        tbl[10] = '{1'b0, 1,     mk(656, 0,   0, 0, 1, 0), "a_col656_hold"};
        tbl[11] = '{1'b0, 189,   mk(751, 0,   0, 0, 1, 0), "a_col751"};
        tbl[12] = '{1'b0, 2,     mk(752, 0,   0, 1, 1, 0), "a_hsync_rise"};
        tbl[13] = '{1'b0, 94,    mk(799, 0,   0, 1, 1, 0), "a_col799"};
        tbl[14] = '{1'b0, 2,     mk(0,   1,   1, 1, 1, 0), "a_row_wrap_0"};
        tbl[15] = '{1'b0, 15998, mk(799, 10,  0, 1, 1, 0), "a_line10_end"};
        tbl[16] = '{1'b0, 2,     mk(0,   11,  1, 1, 1, 0), "a_row_wrap_10"};

        #1;
        for (int i = 0; i < 17; i++) begin
            rst_a = tbl[i].rst;
            push_exp(tbl[i].exp);
            repeat (tbl[i].n) @(posedge clk);
            #1;
            check_pop(tbl[i].name, sample_a());
        end

        // Asynchronous reset between edges on instance a.
        #2 rst_a = 1'b1;
        push_exp(mk(799, 524, 0, 1, 1, 0));
        #1 check_pop("a_async_reset", sample_a());
        rst_a = 1'b0;
        push_exp(mk(799, 524, 0, 1, 1, 0));
        @(posedge clk); #1 check_pop("a_restart_edge1", sample_a());
        push_exp(mk(0, 0, 1, 1, 1, 1));
        @(posedge clk); #1 check_pop("a_restart_tick", sample_a());
        push_exp(mk(0, 0, 1, 1, 1, 0));
        @(posedge clk); #1 check_pop("a_restart_pulse_clear", sample_a());

        // Instance b: reset state, then 400 single-clock pixels.
        repeat (3) @(posedge clk);
        #1;
        push_exp(mk(B_HT - 1, B_VT - 1, 0, 1, 1, 0));
        check_pop("b_reset_hold", sample_b());
        rst_b    = 1'b0;
        fi_count = 0;
        vs_low   = 0;
        for (int t = 1; t <= 400; t++) begin
            @(posedge clk);
            push_exp(model_b((t - 1) % B_FRAME, ((t - 1) % B_FRAME) == 0));
            #1;
            if (bus_b.frameInicio === 1'b1) fi_count++;
            if (bus_b.vsync === 1'b0) vs_low++;
            check_pop("b_cycle", sample_b());
        end
        // Pulses at ticks 1, 196, 391; vsync low 2 lines x 15 clocks, twice.
        check("b_frame_pulses", fi_count, 3);
        check("b_vsync_low_clocks", vs_low, 2 * B_VS * B_HT);

        // Asynchronous mid-frame reset on instance b, then clean restart.
        #2 rst_b = 1'b1;
        push_exp(mk(B_HT - 1, B_VT - 1, 0, 1, 1, 0));
        #1 check_pop("b_async_reset", sample_b());
        rst_b = 1'b0;
        push_exp(mk(0, 0, 1, 1, 1, 1));
        @(posedge clk); #1 check_pop("b_restart_tick", sample_b());
        push_exp(mk(1, 0, 1, 1, 1, 0));
        @(posedge clk); #1 check_pop("b_restart_pulse_clear", sample_b());

        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
